mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory-access pipeline stage, directly downstream of the EX/MEM pipeline register. Consumes the registered ALU result, the destination register and the memory-op controls. Executes loads and stores on a req/gnt/rvalid data bus and stalls the pipeline while a bus transaction is outstanding. Registers the writeback result toward the MEM/WB boundary.

Parameters:
AW, 32, data bus address width
DW, 32, data width (fixed at 32; byte-lane logic assumes 4 lanes)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ex_mem_reg_op_c_i  in  32  ALU result; effective address for memory ops
ex_mem_reg_reg_waddr_i  in  5  destination register
ex_mem_reg_reg_we_i  in  1  register write enable
ex_mem_reg_mem_rd_i  in  1  load
ex_mem_reg_mem_wr_i  in  1  store
ex_mem_reg_mem_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
ex_mem_reg_mem_unsigned_i  in  1  zero-extend load
ex_mem_reg_wdata_i  in  32  store data
dbus_req_o  out  1  bus request
dbus_we_o  out  1  1 = write
dbus_addr_o  out  32  word-aligned address {op_c[31:2],2'b00}
dbus_be_o  out  4  byte enables
dbus_wdata_o  out  32  lane-aligned store data
dbus_gnt_i  in  1  request accepted
dbus_rvalid_i  in  1  response valid (load data or store ack)
dbus_rdata_i  in  32  load data
mem_stall_o  out  1  hold upstream stages; EX/MEM inputs stay stable while high
mem_wb_data_o  out  32  writeback data
mem_wb_reg_waddr_o  out  5  writeback register
mem_wb_reg_we_o  out  1  writeback enable
mem_misalign_o  out  1  one-cycle misaligned/illegal-access flag

Behaviour:
- Reset (async, rst=1): FSM to IDLE. All registered outputs are 0: mem_wb_data_o, mem_wb_reg_waddr_o, mem_wb_reg_we_o, mem_misalign_o. Combinational bus outputs evaluate to 0 in IDLE with no memory op. Reset mid-transaction abandons the access. A late rvalid arriving in IDLE is ignored.
- Memory op is active when mem_rd or mem_wr is high. If both are high, the op is treated as a load.
- Misaligned when any of:
  - size=11
  - size=01 and addr[0]=1
  - size=10 and addr[1:0]!=0
- A misaligned op issues no bus request and causes no stall. It registers mem_misalign_o=1 and mem_wb_reg_we_o=0 for one cycle.
- FSM states: IDLE, REQ, WAIT.
  - IDLE with an aligned memory op: dbus_req_o=1 combinationally, mem_stall_o=1. Go to WAIT if gnt=1, else go to REQ.
  - REQ: req held with constant addr/be/wdata/we. Stall stays 1. Go to WAIT on gnt.
  - WAIT: req=0. Stall=1 until rvalid. On rvalid: stall=0, result registered at that edge, return to IDLE.
  - rvalid in IDLE or REQ is ignored.
- Store lanes:
  - Byte: be=0001<<addr[1:0], wdata = byte replicated x4.
  - Half: be=0011<<(2*addr[1]), wdata = half replicated x2.
  - Word: be=1111.
- Loads: shift rdata right by 8*addr[1:0], take byte or half per size, then sign- or zero-extend per mem_unsigned.
- Writeback register update (each posedge when not stalled):
  - Load: data = extracted load data.
  - Otherwise: data = op_c.
  - waddr and we pass through.
  - Stores do not update the register file unless ex_mem_reg_reg_we_i is set upstream; the upstream decoder clears it for stores.
- While mem_stall_o=1, the output registers load a bubble: we=0, misalign=0, data/waddr hold.
- Latency:
  - Non-memory op: 1 cycle.
  - Load with immediate gnt and rvalid the next cycle: stall for 1 cycle, result valid after cycle 2.

Decomposition:
- Shared package mem_pkg:
  - size encodings MEM_B/MEM_H/MEM_W
  - FSM state encodings S_IDLE/S_REQ/S_WAIT
  - byte-lane count constant
- One combinational sub-module, mem_lsu_align:
  - inputs: size, addr[1:0], unsigned, wdata, rdata
  - outputs: be, lane-aligned wdata, extended load data, misalign
- FSM and output registers stay in mem_stage.

Test Plan:
- ALU op, op_c=0x1234_5678, waddr=5, we=1, no mem op -> next cycle mem_wb_data=0x12345678, waddr=5, we=1; stall never asserted, dbus_req=0.
- Load byte signed, addr=0x1003, gnt same cycle, rvalid+1 with rdata=0x80FF_FF11 -> be=1000, stall high 1 cycle, mem_wb_data=0xFFFFFF80; repeat with unsigned -> 0x00000080.
- Store half, addr=0x2002, wdata=0x0000_BEEF, gnt delayed 3 cycles -> req held 4 cycles with be=1100, wdata=0xBEEFBEEF, we=1; stall released on rvalid; mem_wb_reg_we=0 during stall.
- Load word, addr=0x3001 -> no req, no stall, mem_misalign_o=1 for 1 cycle, mem_wb_reg_we=0.
- Assert rst in WAIT before rvalid, then rvalid pulse after release -> FSM in IDLE, all outputs 0, stray rvalid produces no writeback.
- Back-to-back load word 0x4000 (rdata 0xCAFEBABE) then ALU op -> second instruction writes back the cycle after the load result; no result lost or duplicated.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access pipeline stage.
package mem_pkg;

  // Number of byte lanes on the 32-bit data bus
  localparam int unsigned NUM_LANES = 4;

  // Access size as decoded upstream
  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10,
    MEM_X = 2'b11
  } mem_size_e;

  // Bus transaction state
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10
  } mem_state_e;

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering for stores, extraction and extension for loads,
// and alignment checking for the memory stage.
module mem_lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]           size,
  input  logic [1:0]           addr_lo,
  input  logic                 is_unsigned,
  input  logic [31:0]          wdata,
  input  logic [31:0]          rdata,
  output logic [NUM_LANES-1:0] be,
  output logic [31:0]          wdata_aligned,
  output logic [31:0]          load_data,
  output logic                 misalign
);

  logic [31:0] shifted;

  // Steer store data onto lanes, right-justify and extend load data, flag bad alignment
  always_comb begin
    be            = '0;
    wdata_aligned = '0;
    load_data     = '0;
    misalign      = 1'b0;
    shifted       = rdata >> {addr_lo, 3'b000};
    case (size)
      MEM_B: begin
        be            = 4'b0001 << addr_lo;
        wdata_aligned = {4{wdata[7:0]}};
        load_data     = is_unsigned ? {24'b0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
      end
      MEM_H: begin
        misalign      = addr_lo[0];
        be            = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_aligned = {2{wdata[15:0]}};
        load_data     = is_unsigned ? {16'b0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
      end
      MEM_W: begin
        misalign      = |addr_lo;
        be            = 4'b1111;
        wdata_aligned = wdata;
        load_data     = rdata;
      end
      default: begin
        misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives the req/gnt/rvalid data bus for
// loads and stores, stalls upstream while a transaction is outstanding,
// and registers the writeback result toward MEM/WB.
module mem_stage
  import mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          ex_mem_reg_op_c_i,
  input  logic [4:0]           ex_mem_reg_reg_waddr_i,
  input  logic                 ex_mem_reg_reg_we_i,
  input  logic                 ex_mem_reg_mem_rd_i,
  input  logic                 ex_mem_reg_mem_wr_i,
  input  logic [1:0]           ex_mem_reg_mem_size_i,
  input  logic                 ex_mem_reg_mem_unsigned_i,
  input  logic [DW-1:0]        ex_mem_reg_wdata_i,
  output logic                 dbus_req_o,
  output logic                 dbus_we_o,
  output logic [AW-1:0]        dbus_addr_o,
  output logic [NUM_LANES-1:0] dbus_be_o,
  output logic [DW-1:0]        dbus_wdata_o,
  input  logic                 dbus_gnt_i,
  input  logic                 dbus_rvalid_i,
  input  logic [DW-1:0]        dbus_rdata_i,
  output logic                 mem_stall_o,
  output logic [DW-1:0]        mem_wb_data_o,
  output logic [4:0]           mem_wb_reg_waddr_o,
  output logic                 mem_wb_reg_we_o,
  output logic                 mem_misalign_o
);

  mem_state_e           state;
  mem_state_e           state_next;
  logic                 mem_active;
  logic                 is_store;
  logic                 misalign;
  logic [NUM_LANES-1:0] lane_be;
  logic [31:0]          lane_wdata;
  logic [31:0]          load_data;

  // A load wins when both rd and wr are raised
  assign mem_active = ex_mem_reg_mem_rd_i | ex_mem_reg_mem_wr_i;
  assign is_store   = ex_mem_reg_mem_wr_i & ~ex_mem_reg_mem_rd_i;

  mem_lsu_align u_align (
    .size          (ex_mem_reg_mem_size_i),
    .addr_lo       (ex_mem_reg_op_c_i[1:0]),
    .is_unsigned   (ex_mem_reg_mem_unsigned_i),
    .wdata         (ex_mem_reg_wdata_i),
    .rdata         (dbus_rdata_i),
    .be            (lane_be),
    .wdata_aligned (lane_wdata),
    .load_data     (load_data),
    .misalign      (misalign)
  );

  // Bus handshake decode: request and stall are combinational so an immediate gnt costs no cycle
  always_comb begin
    state_next  = state;
    dbus_req_o  = 1'b0;
    mem_stall_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_active && !misalign) begin
          dbus_req_o  = 1'b1;
          mem_stall_o = 1'b1;
          state_next  = dbus_gnt_i ? S_WAIT : S_REQ;
        end
      end
      S_REQ: begin
        dbus_req_o  = 1'b1;
        mem_stall_o = 1'b1;
        if (dbus_gnt_i) state_next = S_WAIT;
      end
      S_WAIT: begin
        mem_stall_o = ~dbus_rvalid_i;
        if (dbus_rvalid_i) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Address and lane data are only driven while requesting so the bus idles at zero
  always_comb begin
    dbus_we_o    = 1'b0;
    dbus_addr_o  = '0;
    dbus_be_o    = '0;
    dbus_wdata_o = '0;
    if (dbus_req_o) begin
      dbus_we_o   = is_store;
      dbus_addr_o = {ex_mem_reg_op_c_i[AW-1:2], 2'b00};
      dbus_be_o   = lane_be;
      if (is_store) dbus_wdata_o = lane_wdata;
    end
  end

  // Transaction state; reset abandons any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Writeback register: bubble while stalled, flag misaligned ops, otherwise pass the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wb_data_o      <= '0;
      mem_wb_reg_waddr_o <= '0;
      mem_wb_reg_we_o    <= 1'b0;
      mem_misalign_o     <= 1'b0;
    end else if (mem_stall_o) begin
      mem_wb_reg_we_o <= 1'b0;
      mem_misalign_o  <= 1'b0;
    end else if (state == S_IDLE && mem_active && misalign) begin
      mem_wb_data_o      <= ex_mem_reg_op_c_i;
      mem_wb_reg_waddr_o <= ex_mem_reg_reg_waddr_i;
      mem_wb_reg_we_o    <= 1'b0;
      mem_misalign_o     <= 1'b1;
    end else begin
      mem_wb_data_o      <= ex_mem_reg_mem_rd_i ? load_data : ex_mem_reg_op_c_i;
      mem_wb_reg_waddr_o <= ex_mem_reg_reg_waddr_i;
      mem_wb_reg_we_o    <= ex_mem_reg_reg_we_i;
      mem_misalign_o     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [31:0] op_c;
  logic [4:0]  waddr;
  logic        reg_we;
  logic        mem_rd;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic        mem_uns;
  logic [31:0] st_wdata;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        mem_stall;
  logic [31:0] wb_data;
  logic [4:0]  wb_waddr;
  logic        wb_we;
  logic        misalign;

  int pass_count  = 0;
  int check_count = 0;

  mem_stage #(.AW(32), .DW(32)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .ex_mem_reg_op_c_i         (op_c),
    .ex_mem_reg_reg_waddr_i    (waddr),
    .ex_mem_reg_reg_we_i       (reg_we),
    .ex_mem_reg_mem_rd_i       (mem_rd),
    .ex_mem_reg_mem_wr_i       (mem_wr),
    .ex_mem_reg_mem_size_i     (mem_size),
    .ex_mem_reg_mem_unsigned_i (mem_uns),
    .ex_mem_reg_wdata_i        (st_wdata),
    .dbus_req_o                (dbus_req),
    .dbus_we_o                 (dbus_we),
    .dbus_addr_o               (dbus_addr),
    .dbus_be_o                 (dbus_be),
    .dbus_wdata_o              (dbus_wdata),
    .dbus_gnt_i                (dbus_gnt),
    .dbus_rvalid_i             (dbus_rvalid),
    .dbus_rdata_i              (dbus_rdata),
    .mem_stall_o               (mem_stall),
    .mem_wb_data_o             (wb_data),
    .mem_wb_reg_waddr_o        (wb_waddr),
    .mem_wb_reg_we_o           (wb_we),
    .mem_misalign_o            (misalign)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] c, input logic [4:0] wa, input logic we,
                               input logic rd, input logic wr, input logic [1:0] sz,
                               input logic uns, input logic [31:0] wd);
    op_c     = c;
    waddr    = wa;
    reg_we   = we;
    mem_rd   = rd;
    mem_wr   = wr;
    mem_size = sz;
    mem_uns  = uns;
    st_wdata = wd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) begin
      pass_count++;
    end else begin
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic bubble();
    applyStimulus(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
  endtask

  initial begin
    rst         = 1'b1;
    dbus_gnt    = 1'b0;
    dbus_rvalid = 1'b0;
    dbus_rdata  = 32'h0;
    applyStimulus(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
    #1;
    checkOutput("reset_wb_data", wb_data, 32'h0);
    checkOutput("reset_wb_waddr", {27'b0, wb_waddr}, 32'h0);
    checkOutput("reset_wb_we", {31'b0, wb_we}, 32'h0);
    checkOutput("reset_misalign", {31'b0, misalign}, 32'h0);
    checkOutput("reset_req", {31'b0, dbus_req}, 32'h0);
    checkOutput("reset_stall", {31'b0, mem_stall}, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // ALU op passes straight through in one cycle
    applyStimulus(32'h1234_5678, 5'd5, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0);
    checkOutput("alu_stall", {31'b0, mem_stall}, 32'h0);
    checkOutput("alu_req", {31'b0, dbus_req}, 32'h0);
    tick();
    checkOutput("alu_wb_data", wb_data, 32'h1234_5678);
    checkOutput("alu_wb_waddr", {27'b0, wb_waddr}, 32'd5);
    checkOutput("alu_wb_we", {31'b0, wb_we}, 32'h1);
    bubble();

    // Signed then unsigned byte load from the top lane
    for (int u = 0; u < 2; u++) begin
      dbus_gnt = 1'b1;
      applyStimulus(32'h0000_1003, 5'd7, 1'b1, 1'b1, 1'b0, 2'b00, u[0], 32'h0);
      checkOutput("lb_req", {31'b0, dbus_req}, 32'h1);
      checkOutput("lb_be", {28'b0, dbus_be}, 32'h8);
      checkOutput("lb_addr", dbus_addr, 32'h0000_1000);
      checkOutput("lb_bus_we", {31'b0, dbus_we}, 32'h0);
      checkOutput("lb_stall", {31'b0, mem_stall}, 32'h1);
      tick();
      dbus_gnt    = 1'b0;
      dbus_rvalid = 1'b1;
      dbus_rdata  = 32'h80FF_FF11;
      #1;
      checkOutput("lb_wait_req", {31'b0, dbus_req}, 32'h0);
      checkOutput("lb_wait_stall", {31'b0, mem_stall}, 32'h0);
      checkOutput("lb_bubble_we", {31'b0, wb_we}, 32'h0);
      tick();
      dbus_rvalid = 1'b0;
      checkOutput("lb_wb_data", wb_data, (u == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      checkOutput("lb_wb_waddr", {27'b0, wb_waddr}, 32'd7);
      checkOutput("lb_wb_we", {31'b0, wb_we}, 32'h1);
      bubble();
    end

    // Half store with grant held off for three cycles
    applyStimulus(32'h0000_2002, 5'd0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_BEEF);
    for (int c = 0; c < 4; c++) begin
      dbus_gnt = (c == 3);
      #1;
      checkOutput("sh_req", {31'b0, dbus_req}, 32'h1);
      checkOutput("sh_be", {28'b0, dbus_be}, 32'hC);
      checkOutput("sh_wdata", dbus_wdata, 32'hBEEF_BEEF);
      checkOutput("sh_bus_we", {31'b0, dbus_we}, 32'h1);
      checkOutput("sh_addr", dbus_addr, 32'h0000_2000);
      checkOutput("sh_stall", {31'b0, mem_stall}, 32'h1);
      if (c > 0) checkOutput("sh_wb_we_stalled", {31'b0, wb_we}, 32'h0);
      tick();
    end
    dbus_gnt = 1'b0;
    #1;
    checkOutput("sh_wait_req", {31'b0, dbus_req}, 32'h0);
    checkOutput("sh_wait_stall", {31'b0, mem_stall}, 32'h1);
    tick();
    dbus_rvalid = 1'b1;
    #1;
    checkOutput("sh_ack_stall", {31'b0, mem_stall}, 32'h0);
    tick();
    dbus_rvalid = 1'b0;
    checkOutput("sh_wb_we", {31'b0, wb_we}, 32'h0);
    checkOutput("sh_misalign", {31'b0, misalign}, 32'h0);
    bubble();

    // Misaligned word load raises the flag for exactly one cycle
    applyStimulus(32'h0000_3001, 5'd3, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0);
    checkOutput("mis_req", {31'b0, dbus_req}, 32'h0);
    checkOutput("mis_stall", {31'b0, mem_stall}, 32'h0);
    tick();
    checkOutput("mis_flag", {31'b0, misalign}, 32'h1);
    checkOutput("mis_wb_we", {31'b0, wb_we}, 32'h0);
    bubble();
    tick();
    checkOutput("mis_flag_clear", {31'b0, misalign}, 32'h0);

    // Reset while waiting for the response, then a stray rvalid
    dbus_gnt = 1'b1;
    applyStimulus(32'h0000_5000, 5'd4, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0);
    tick();
    dbus_gnt = 1'b0;
    #1;
    checkOutput("rst_wait_stall", {31'b0, mem_stall}, 32'h1);
    bubble();
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_stall", {31'b0, mem_stall}, 32'h0);
    checkOutput("rst_mid_wb_data", wb_data, 32'h0);
    checkOutput("rst_mid_wb_we", {31'b0, wb_we}, 32'h0);
    tick();
    rst = 1'b0;
    dbus_rvalid = 1'b1;
    dbus_rdata  = 32'hDEAD_BEEF;
    #1;
    checkOutput("stray_stall", {31'b0, mem_stall}, 32'h0);
    checkOutput("stray_req", {31'b0, dbus_req}, 32'h0);
    tick();
    dbus_rvalid = 1'b0;
    checkOutput("stray_wb_we", {31'b0, wb_we}, 32'h0);
    checkOutput("stray_wb_data", wb_data, 32'h0);

    // Word load followed immediately by an ALU op
    dbus_gnt = 1'b1;
    applyStimulus(32'h0000_4000, 5'd9, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0);
    checkOutput("lw_be", {28'b0, dbus_be}, 32'hF);
    tick();
    dbus_gnt    = 1'b0;
    dbus_rvalid = 1'b1;
    dbus_rdata  = 32'hCAFE_BABE;
    tick();
    dbus_rvalid = 1'b0;
    checkOutput("lw_wb_data", wb_data, 32'hCAFE_BABE);
    checkOutput("lw_wb_waddr", {27'b0, wb_waddr}, 32'd9);
    checkOutput("lw_wb_we", {31'b0, wb_we}, 32'h1);
    applyStimulus(32'h0000_0011, 5'd10, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0);
    tick();
    checkOutput("b2b_wb_data", wb_data, 32'h0000_0011);
    checkOutput("b2b_wb_waddr", {27'b0, wb_waddr}, 32'd10);
    checkOutput("b2b_wb_we", {31'b0, wb_we}, 32'h1);
    bubble();
    tick();
    checkOutput("b2b_no_dup_we", {31'b0, wb_we}, 32'h0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
